// File: rtl/scorer_match.sv
// scorer_match: tug-of-war rope scorer with multi-game match tracking.
// Holds the rope position, steps it on each decided round, latches game wins,
// counts games per side and flags the match winner. Drives the LED bar image.
// Optional feature: define SCORER_DOUBLE_EN to let a proper push move two
// cells when the latched switch for the current cell is set.
module scorer_match #(
    parameter int HALF         = 3,
    parameter int MATCH_POINTS = 2,
    parameter int CNT_W        = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                winrnd,
    input  logic                tie,
    input  logic                right,
    input  logic                leds_on,
    input  logic [2*HALF:0]     switches_in,
    input  logic                new_game,
    output logic [2*HALF+1:0]   score,
    output logic                game_over,
    output logic                winner_right,
    output logic [CNT_W-1:0]    l_games,
    output logic [CNT_W-1:0]    r_games,
    output logic                match_over
);

    localparam int W   = 2*HALF+2;
    localparam int P   = 2*HALF+1;
    localparam int WIN = HALF+1;
    // Position width leaves headroom for a 2-cell overshoot before clamping.
    localparam int PW  = $clog2(HALF+4)+2;

    // LED bar image for a signed rope position.
    function automatic logic [W-1:0] bar_img(input int p);
        logic [W-1:0] r;
        r = '0;
        for (int c = 0; c < W; c++) begin
            if (p == 0 && (c == HALF || c == HALF+1))   r[c] = 1'b1;
            if (p > 0 && p <= HALF && c == HALF-p)      r[c] = 1'b1;
            if (p < 0 && p >= -HALF && c == HALF+1-p)   r[c] = 1'b1;
            if (p == WIN && c < HALF)                   r[c] = 1'b1;
            if (p == -WIN && c >= HALF+2)               r[c] = 1'b1;
        end
        return r;
    endfunction

    localparam logic [W-1:0] NEUTRAL = bar_img(0);

    logic signed [PW-1:0] pos, pos_nxt;
    logic                 go_nxt, wr_nxt, mo_nxt;
    logic [CNT_W-1:0]     lg_nxt, rg_nxt;
    logic [W-1:0]         score_nxt;
    logic                 mr;
    int                   p, np, step;

`ifdef SCORER_DOUBLE_EN
    logic [P-1:0] sw_lat;
    logic         dbl_bit;

    // Switch mask is captured only while the rope sits at neutral.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           sw_lat <= '0;
        else if (pos == '0) sw_lat <= switches_in;
    end

    // Latched switch bit for the cell the rope currently occupies.
    always_comb begin
        dbl_bit = 1'b0;
        for (int c = 0; c < P; c++)
            if (c == int'(pos) + HALF) dbl_bit = sw_lat[c];
    end
`else
    logic unused_sw;
    assign unused_sw = ^switches_in;
`endif

    // State register: rope, game/match flags, counters, registered LED bar.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos          <= '0;
            game_over    <= 1'b0;
            winner_right <= 1'b0;
            l_games      <= '0;
            r_games      <= '0;
            match_over   <= 1'b0;
            score        <= NEUTRAL;
        end else begin
            pos          <= pos_nxt;
            game_over    <= go_nxt;
            winner_right <= wr_nxt;
            l_games      <= lg_nxt;
            r_games      <= rg_nxt;
            match_over   <= mo_nxt;
            score        <= score_nxt;
        end
    end

    // Next state: new_game has priority over a round; moves freeze once a game is won.
    always_comb begin
        pos_nxt = pos;
        go_nxt  = game_over;
        wr_nxt  = winner_right;
        lg_nxt  = l_games;
        rg_nxt  = r_games;
        mo_nxt  = match_over;
        p       = int'(pos);
        np      = p;
        step    = 1;
        mr      = ~(right ^ leds_on);
        if (new_game) begin
            if (game_over) begin
                pos_nxt = '0;
                go_nxt  = 1'b0;
                if (match_over) begin
                    lg_nxt = '0;
                    rg_nxt = '0;
                    mo_nxt = 1'b0;
                end
            end
        end else if (winrnd && !tie && !game_over) begin
`ifdef SCORER_DOUBLE_EN
            if (leds_on && dbl_bit && (mr ? (p >= 0) : (p <= 0))) step = 2;
`endif
            np = mr ? p + step : p - step;
            if (np > WIN)  np = WIN;
            if (np < -WIN) np = -WIN;
            pos_nxt = np[PW-1:0];
            if (np == WIN || np == -WIN) begin
                go_nxt = 1'b1;
                wr_nxt = (np > 0);
                if (np > 0) begin
                    if (r_games != '1) rg_nxt = r_games + CNT_W'(1);
                    if (rg_nxt == CNT_W'(MATCH_POINTS)) mo_nxt = 1'b1;
                end else begin
                    if (l_games != '1) lg_nxt = l_games + CNT_W'(1);
                    if (lg_nxt == CNT_W'(MATCH_POINTS)) mo_nxt = 1'b1;
                end
            end
        end
    end

    // Output image follows the next rope position so score lines up with pos.
    always_comb begin
        score_nxt = bar_img(int'(pos_nxt));
    end

endmodule

// File: tb/tb_scorer_match.sv
// Randomized and directed bench for scorer_match (HALF=3, MATCH_POINTS=2, CNT_W=4).
module tb_scorer_match;
    localparam int HALF = 3;
    localparam int MP   = 2;
    localparam int CW   = 4;
    localparam int W    = 2*HALF+2;
    localparam int WIN  = HALF+1;

    logic clk = 0, rst = 0;
    logic winrnd = 0, tie = 0, right = 0, leds_on = 0, new_game = 0;
    logic [2*HALF:0] switches_in = '0;
    logic [W-1:0] score;
    logic game_over, winner_right, match_over;
    logic [CW-1:0] l_games, r_games;

    int nchk = 0, nerr = 0;

    // reference model state
    int m_pos, m_lg, m_rg;
    bit m_go, m_wr, m_mo;
    logic [2*HALF:0] m_sw;

    scorer_match #(.HALF(HALF), .MATCH_POINTS(MP), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .winrnd(winrnd), .tie(tie), .right(right),
        .leds_on(leds_on), .switches_in(switches_in), .new_game(new_game),
        .score(score), .game_over(game_over), .winner_right(winner_right),
        .l_games(l_games), .r_games(r_games), .match_over(match_over));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int img(input int p);
        if (p == 0)     return (1 << HALF) | (1 << (HALF+1));
        if (p == WIN)   return (1 << HALF) - 1;
        if (p == -WIN)  return ((1 << W) - 1) ^ ((1 << (HALF+2)) - 1);
        if (p > 0)      return 1 << (HALF-p);
        return 1 << (HALF+1-p);
    endfunction

    task automatic m_reset();
        m_pos = 0; m_lg = 0; m_rg = 0; m_go = 0; m_wr = 0; m_mo = 0; m_sw = '0;
    endtask

    // One clock edge of the game rules applied to the model.
    task automatic m_edge(input bit wr, input bit t, input bit r, input bit l,
                          input logic [2*HALF:0] sw, input bit ng);
        int old, dir, st;
        old = m_pos;
        if (ng) begin
            if (m_go) begin
                m_pos = 0; m_go = 0;
                if (m_mo) begin m_lg = 0; m_rg = 0; m_mo = 0; end
            end
        end else if (wr && !t && !m_go) begin
            dir = (r == l) ? 1 : -1;
            st = 1;
`ifdef SCORER_DOUBLE_EN
            if (l && m_sw[m_pos+HALF] && (dir > 0 ? m_pos >= 0 : m_pos <= 0)) st = 2;
`endif
            m_pos = m_pos + dir*st;
            if (m_pos > WIN)  m_pos = WIN;
            if (m_pos < -WIN) m_pos = -WIN;
            if (m_pos == WIN || m_pos == -WIN) begin
                m_go = 1; m_wr = (m_pos > 0);
                if (m_wr) begin
                    if (m_rg < (1 << CW) - 1) m_rg++;
                    if (m_rg == MP) m_mo = 1;
                end else begin
                    if (m_lg < (1 << CW) - 1) m_lg++;
                    if (m_lg == MP) m_mo = 1;
                end
            end
        end
        if (old == 0) m_sw = sw;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".score"}, int'(score), img(m_pos));
        chk({tag, ".go"}, int'(game_over), int'(m_go));
        if (m_go) chk({tag, ".wr"}, int'(winner_right), int'(m_wr));
        chk({tag, ".lg"}, int'(l_games), m_lg);
        chk({tag, ".rg"}, int'(r_games), m_rg);
        chk({tag, ".mo"}, int'(match_over), int'(m_mo));
    endtask

    task automatic cyc(input string tag, input bit wr, input bit t, input bit r,
                       input bit l, input logic [2*HALF:0] sw, input bit ng);
        @(negedge clk);
        winrnd = wr; tie = t; right = r; leds_on = l; switches_in = sw; new_game = ng;
        @(posedge clk);
        m_edge(wr, t, r, l, sw, ng);
        #1 check_all(tag);
    endtask

    logic [7:0] exp2 [4] = '{8'h04, 8'h02, 8'h01, 8'h07};

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1 chk("rst.score", int'(score), 8'h18);
        chk("rst.go", int'(game_over), 0);
        chk("rst.wr", int'(winner_right), 0);
        chk("rst.cnt", int'({l_games, r_games}), 0);
        chk("rst.mo", int'(match_over), 0);
        @(negedge clk) rst = 1;

        // right wins a game with four proper pushes
        for (int i = 0; i < 4; i++) begin
            cyc("t2", 1, 0, 1, 1, '0, 0);
            chk("t2.bar", int'(score), int'(exp2[i]));
        end
        chk("t2.win", int'({game_over, winner_right, r_games}), 'h31);

        // jump-the-light by left moves rope right; tie holds
        cyc("t3.ng", 0, 0, 0, 0, '0, 1);
        chk("t3.neutral", int'(score), 8'h18);
        cyc("t3.jump", 1, 0, 0, 0, '0, 0);
        chk("t3.bar", int'(score), 8'h04);
        cyc("t3.tie", 1, 1, 0, 1, '0, 0);
        chk("t3.tiebar", int'(score), 8'h04);

        // second right game win ends the match
        for (int i = 0; i < 3; i++) cyc("t5", 1, 0, 1, 1, '0, 0);
        chk("t5.match", int'({match_over, r_games}), 'h12);
        cyc("t5.ng", 0, 0, 0, 0, '0, 1);
        chk("t5.clr", int'({match_over, l_games, r_games, score}), 'h18);

`ifdef SCORER_DOUBLE_EN
        cyc("t4.lat", 0, 0, 0, 0, 7'b0001000, 0);
        cyc("t4.dbl", 1, 0, 0, 1, 7'b0001000, 0);
        chk("t4.L2", int'(score), 8'h40);
        cyc("t4.sgl", 1, 0, 0, 1, 7'b0001000, 0);
        chk("t4.L3", int'(score), 8'h80);
`endif

        // left win (bounded), then new_game collides with winrnd
        for (int i = 0; i < 10 && !m_go; i++) cyc("t6.l", 1, 0, 0, 1, '0, 0);
        chk("t6.lwin", int'({game_over, winner_right}), 2);
        cyc("t6.coll", 1, 0, 1, 1, '0, 1);
        chk("t6.neutral", int'({game_over, score}), 8'h18);

        // async reset mid-game
        cyc("t6.mv", 1, 0, 1, 1, '0, 0);
        cyc("t6.mv", 1, 0, 1, 1, '0, 0);
        @(negedge clk); winrnd = 0; new_game = 0;
        #2 rst = 0;
        #1 m_reset();
        chk("arst.score", int'(score), 8'h18);
        chk("arst.cnt", int'({l_games, r_games, game_over}), 0);
        @(negedge clk) rst = 1;

        // randomized play against the model
        for (int i = 0; i < 600; i++) begin
            bit wr, ng;
            wr = ($urandom % 2) == 0;
            ng = m_go ? (($urandom % 4) == 0) : (!wr && ($urandom % 16) == 0);
            cyc("rnd", wr, ($urandom % 5) == 0, 1'($urandom), ($urandom % 4) != 0,
                7'($urandom), ng);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
